// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel debouncer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents:
//   dbc_state_e  - per-channel press/hold/auto-repeat state
//   timer_width  - repeat-timer width large enough for both repeat intervals
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } dbc_state_e;

  // The timer only has to reach (interval - 1), so clog2 of the larger
  // interval is enough; never return a zero-width timer.
  function automatic int timer_width(input int delay, input int period);
    int span;
    span = (delay > period) ? delay : period;
    return (span < 2) ? 1 : $clog2(span);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop sync, saturating hysteresis counter, press/release/auto-repeat FSM.
// Latency: level and pulses register 2 sync edges + threshold-crossing counts after the raw input settles.
// Backpressure: none; pulses are single-cycle and are not held for a consumer.
//
// Ports:
//   clk_i      - system clock, rising edge
//   reset_i    - synchronous active-high reset
//   raw_i      - asynchronous bouncing input
//   level_o    - debounced level (counter MSB)
//   press_o    - one-cycle pulse on debounced rise and each auto-repeat
//   release_o  - one-cycle pulse on debounced fall
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int COUNTER_BITS  = 7,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int CW = COUNTER_BITS;
  localparam int TW = timer_width(REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};
  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  dbc_state_e    state_q, state_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          rise, fall;

  // Saturating up/down counter driven only by the second sync flop.
  always_comb begin
    cnt_d = cnt_q;
    if (sync2_q) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
    end else begin
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
    end
  end

  // MSB crossings give hysteresis: the level only moves at the midpoint.
  assign rise = ~cnt_q[CW-1] &  cnt_d[CW-1];
  assign fall =  cnt_q[CW-1] & ~cnt_d[CW-1];

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (rise) begin
          state_d = HELD;
          press_d = 1'b1;
        end
      end
      HELD: begin
        // A fall is checked first so it beats a coincident timer expiry.
        if (fall) begin
          state_d   = IDLE;
          release_d = 1'b1;
          timer_d   = '0;
        end else if (REPEAT_EN != 0) begin
          if (timer_q == DELAY_LAST) begin
            state_d = REPEAT;
            press_d = 1'b1;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end else begin
          timer_d = '0;
        end
      end
      REPEAT: begin
        if (fall) begin
          state_d   = IDLE;
          release_d = 1'b1;
          timer_d   = '0;
        end else if (timer_q == PERIOD_LAST) begin
          press_d = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      timer_q   <= '0;
      state_q   <= IDLE;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = cnt_q[CW-1];
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/multi_debouncer.sv
// Bank of independent debounce channels with a combined registered event flag.
// Latency: per-channel as in debounce_channel; any_event one cycle after the pulses.
// Backpressure: none; all outputs are free-running.
//
// Ports:
//   clk            - system clock, rising edge
//   reset          - synchronous active-high reset
//   input_unstable - raw bouncing inputs, one per channel
//   level_stable   - debounced levels
//   press_pulse    - press / auto-repeat pulses
//   release_pulse  - release pulses
//   any_event      - registered OR of all press and release pulses
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int COUNTER_BITS  = 7,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] input_unstable,
  output logic [CHANNELS-1:0] level_stable,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic                any_event
);

  logic any_event_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .COUNTER_BITS (COUNTER_BITS),
      .REPEAT_EN    (REPEAT_EN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk_i    (clk),
      .reset_i  (reset),
      .raw_i    (input_unstable[i]),
      .level_o  (level_stable[i]),
      .press_o  (press_pulse[i]),
      .release_o(release_pulse[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) any_event_q <= 1'b0;
    else       any_event_q <= |(press_pulse | release_pulse);
  end

  assign any_event = any_event_q;

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer, COUNTER_BITS=3 (threshold 4, max 7).
// Two instances share the inputs: one with auto-repeat (delay 10, period 3), one without.
// Outputs are sampled 1 time unit after each rising edge.
module tb_multi_debouncer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] in_vec = 4'b0000;

  logic [3:0] lvl_r, prs_r, rel_r;
  logic       any_r;
  logic [3:0] lvl_n, prs_n, rel_n;
  logic       any_n;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;

  multi_debouncer #(
    .CHANNELS(4), .COUNTER_BITS(3), .REPEAT_EN(1),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut_rep (
    .clk(clk), .reset(reset), .input_unstable(in_vec),
    .level_stable(lvl_r), .press_pulse(prs_r),
    .release_pulse(rel_r), .any_event(any_r)
  );

  multi_debouncer #(
    .CHANNELS(4), .COUNTER_BITS(3), .REPEAT_EN(0),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut_norep (
    .clk(clk), .reset(reset), .input_unstable(in_vec),
    .level_stable(lvl_n), .press_pulse(prs_n),
    .release_pulse(rel_n), .any_event(any_n)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    in_vec = 4'b0000;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  // {level, press, release, any_event}
  function automatic logic [31:0] ex(input logic [3:0] l, input logic [3:0] p,
                                     input logic [3:0] r, input logic a);
    return {19'd0, l, p, r, a};
  endfunction

  function automatic logic [31:0] obs_rep();
    return {19'd0, lvl_r, prs_r, rel_r, any_r};
  endfunction

  function automatic logic [31:0] obs_norep();
    return {19'd0, lvl_n, prs_n, rel_n, any_n};
  endfunction

  initial begin
    logic [3:0] l, p, pn, r;
    logic       prev, prevn;

    // Reset held with all inputs high: everything stays 0.
    reset  = 1'b1;
    in_vec = 4'b1111;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_vec($sformatf("reset_rep c%0d", k), obs_rep(), 32'd0);
      check_vec($sformatf("reset_norep c%0d", k), obs_norep(), 32'd0);
    end

    // Channel 0 step: press on the 6th edge, any_event one edge later.
    do_reset();
    in_vec = 4'b0001;
    prev = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      l = (k >= 6) ? 4'b0001 : 4'b0000;
      p = (k == 6) ? 4'b0001 : 4'b0000;
      check_vec($sformatf("ch0_step k=%0d", k), obs_rep(), ex(l, p, 4'b0000, prev));
      prev = |p;
    end

    // Channel 1 saturated, then bouncing 0/1, then held low (no-repeat instance).
    do_reset();
    in_vec = 4'b0010;
    prev = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      l = (k >= 6) ? 4'b0010 : 4'b0000;
      p = (k == 6) ? 4'b0010 : 4'b0000;
      check_vec($sformatf("ch1_rise k=%0d", k), obs_norep(), ex(l, p, 4'b0000, prev));
      prev = |p;
    end
    for (int j = 0; j < 40; j++) begin
      in_vec = (j % 2 == 0) ? 4'b0000 : 4'b0010;
      tick();
      check_vec($sformatf("ch1_bounce j=%0d", j), obs_norep(), ex(4'b0010, 4'b0000, 4'b0000, 1'b0));
    end
    in_vec = 4'b0000;
    prev = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      l = (k < 6) ? 4'b0010 : 4'b0000;
      r = (k == 6) ? 4'b0010 : 4'b0000;
      check_vec($sformatf("ch1_fall k=%0d", k), obs_norep(), ex(l, 4'b0000, r, prev));
      prev = |r;
    end

    // Channel 2 held: repeats at 6,16,19,...; input dropped after edge 30 -> fall at 36.
    do_reset();
    in_vec = 4'b0100;
    prev  = 1'b0;
    prevn = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      l  = (k >= 6 && k < 36) ? 4'b0100 : 4'b0000;
      p  = (k == 6 || (k >= 16 && k < 36 && (k - 16) % 3 == 0)) ? 4'b0100 : 4'b0000;
      pn = (k == 6) ? 4'b0100 : 4'b0000;
      r  = (k == 36) ? 4'b0100 : 4'b0000;
      check_vec($sformatf("ch2_rep k=%0d", k), obs_rep(), ex(l, p, r, prev));
      check_vec($sformatf("ch2_norep k=%0d", k), obs_norep(), ex(l, pn, r, prevn));
      prev  = |(p | r);
      prevn = |(pn | r);
      if (k == 30) in_vec = 4'b0000;
    end

    // Fall lands on the repeat expiry at edge 22: release only; re-press restarts timer.
    do_reset();
    in_vec = 4'b0100;
    prev = 1'b0;
    for (int k = 1; k <= 56; k++) begin
      tick();
      l = ((k >= 6 && k < 22) || k >= 36) ? 4'b0100 : 4'b0000;
      p = (k == 6 || k == 16 || k == 19 || k == 36 ||
           (k >= 46 && (k - 46) % 3 == 0)) ? 4'b0100 : 4'b0000;
      r = (k == 22) ? 4'b0100 : 4'b0000;
      check_vec($sformatf("tie k=%0d", k), obs_rep(), ex(l, p, r, prev));
      prev = |(p | r);
      if (k == 16) in_vec = 4'b0000;
      if (k == 30) in_vec = 4'b0100;
    end

    // Reset pulsed while repeating with input still high.
    do_reset();
    in_vec = 4'b0100;
    repeat (20) tick();
    reset = 1'b1;
    tick();
    check_vec("mid_reset", obs_rep(), 32'd0);
    reset = 1'b0;
    prev = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      l = (k >= 6) ? 4'b0100 : 4'b0000;
      p = (k == 6) ? 4'b0100 : 4'b0000;
      check_vec($sformatf("post_reset k=%0d", k), obs_rep(), ex(l, p, 4'b0000, prev));
      prev = |p;
    end

    // Simultaneous events on channels 0, 1 and 3.
    do_reset();
    in_vec = 4'b1011;
    prev = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      l = (k >= 6 && k <= 13) ? 4'b1011 : 4'b0000;
      p = (k == 6) ? 4'b1011 : 4'b0000;
      r = (k == 14) ? 4'b1011 : 4'b0000;
      check_vec($sformatf("multi k=%0d", k), obs_norep(), ex(l, p, r, prev));
      prev = |(p | r);
      if (k == 8) in_vec = 4'b0000;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent input channels, 1..32.
REQ-002 Parameter COUNTER_BITS, default 7: width of each hysteresis counter, 2..16; switching threshold is 2**(COUNTER_BITS-1).
REQ-003 Parameter REPEAT_EN, default 0: 1 enables auto-repeat press pulses while a channel is held.
REQ-004 Parameter REPEAT_DELAY, default 500: cycles from the initial press pulse to the first repeat pulse, at least 2.
REQ-005 Parameter REPEAT_PERIOD, default 100: cycles between successive repeat pulses, at least 2.
REQ-006 Port clk  input  1  single system clock; all logic on its rising edge.
REQ-007 Port reset  input  1  synchronous, active-high reset.
REQ-008 Port input_unstable  input  CHANNELS  raw asynchronous, bouncing inputs, one bit per channel.
REQ-009 Port level_stable  output  CHANNELS  debounced level per channel.
REQ-010 Port press_pulse  output  CHANNELS  one-cycle pulse on debounced rise and on each auto-repeat.
REQ-011 Port release_pulse  output  CHANNELS  one-cycle pulse on debounced fall.
REQ-012 Port any_event  output  1  registered OR of all press_pulse and release_pulse bits.

Function
REQ-013 Each channel SHALL pass its input through a 2-flop synchroniser; the counter sees only the second flop.
REQ-014 Each counter SHALL increment when the synchronised input is 1 and decrement when it is 0, saturating at 2**COUNTER_BITS-1 and 0; it SHALL never wrap.
REQ-015 level_stable[i] SHALL equal the counter MSB after the update; it rises on the 2**(COUNTER_BITS-1)-1 to 2**(COUNTER_BITS-1) step and falls on the reverse step, giving hysteresis.
REQ-016 press_pulse[i] SHALL be registered high for exactly one cycle at the same edge at which level_stable[i] goes 0 to 1; release_pulse[i] likewise on 1 to 0.
REQ-017 Each channel SHALL run an FSM with states IDLE, HELD and REPEAT: IDLE goes to HELD on a level rise, and HELD or REPEAT goes to IDLE on a level fall.
REQ-018 In HELD with REPEAT_EN=1, a repeat timer SHALL count from 0 after the initial press; at REPEAT_DELAY cycles after that press, press_pulse SHALL fire, the timer SHALL clear and the FSM SHALL enter REPEAT.
REQ-019 In REPEAT, press_pulse SHALL fire every REPEAT_PERIOD cycles while the level stays high.
REQ-020 With REPEAT_EN=0 the FSM SHALL remain in HELD and the timer SHALL stay at 0.
REQ-021 If a level fall and a timer expiry occur at the same edge, the fall SHALL win: release_pulse fires, press_pulse does not, FSM goes to IDLE and the timer clears.
REQ-022 press_pulse[i] and release_pulse[i] SHALL never be high in the same cycle.
REQ-023 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses.
REQ-024 any_event SHALL lag the pulse outputs by one cycle.

Reset
REQ-025 While reset=1 at an edge, synchronisers, counters and timers SHALL clear to 0, FSMs SHALL go to IDLE, and all outputs SHALL be 0 after that edge.
REQ-026 Reset mid-hold SHALL discard all state; a still-high input SHALL produce a new press only after the counter rebuilds from 0.

Structure
REQ-027 Package debounce_pkg SHALL hold the FSM state enum (IDLE, HELD, REPEAT) and a clog2-based width function for the repeat timer.
REQ-028 Per-channel logic SHALL be sub-module debounce_channel, instantiated CHANNELS times by generate; the top level holds only instances and the any_event register.

Verification (COUNTER_BITS=3: threshold 4, max 7)
REQ-029 Reset with all inputs high for 5 cycles -> every output is 0 throughout.
REQ-030 Channel 0 steps to 1 and stays high, other channels 0 -> press_pulse[0] high for exactly the cycle after the 6th edge following the step (2 sync + 4 counts); level_stable=4'b0001; no other pulses.
REQ-031 Channel 1 saturated at 7, input alternating 0,1 for 40 cycles -> level_stable[1] stays 1 with no pulses; then input held at 0 -> release_pulse[1] 6 edges after the first 0 of the hold.
REQ-032 REPEAT_EN=1, REPEAT_DELAY=10, REPEAT_PERIOD=3, channel 2 held high -> press pulses at t0, t0+10, t0+13, t0+16, ...; after release, no further presses.
REQ-033 Input falls so that the level fall lands on the same edge as a repeat expiry -> release pulse only, FSM IDLE.
REQ-034 Reset pulsed in REPEAT with input still high -> outputs 0 the next cycle; next press 6 edges after reset deasserts.
